// File: rtl/popcount_pkg.sv
// Shared sizing helpers for the pipelined popcount: counter width, tree depth,
// pipeline latency and the bit offsets of each adder level on the flat tree bus.
package popcount_pkg;

  localparam int DEF_THRESHOLD = 4;
  localparam int DEF_ACC_W     = 32;

  function automatic int clog2_f(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  function automatic int count_w(input int width);
    return clog2_f(width + 1);
  endfunction

  function automatic int pipe_lat(input int width, input int reg_every);
    int l;
    l = (clog2_f(width) + reg_every - 1) / reg_every;
    return (l < 1) ? 1 : l;
  endfunction

  // Bits used by levels 0..k-1: level j emits n>>(j+1) sums of j+2 bits.
  function automatic int tree_off(input int n, input int k);
    int off;
    off = 0;
    for (int j = 0; j < k; j++) off += (n >> (j + 1)) * (j + 2);
    return off;
  endfunction

endpackage

// File: rtl/popcount_tree_level.sv
// One adder-tree level: pairs of IW-bit sums become IW+1-bit sums, optionally
// registered behind the global pipeline enable.
module popcount_tree_level #(
  parameter int N_IN = 2,
  parameter int IW   = 1,
  parameter bit REG  = 1'b0
) (
  input  logic                        clock,
  input  logic                        reset_n,
  input  logic                        en_i,
  input  logic [N_IN*IW-1:0]          sums_i,
  output logic [(N_IN/2)*(IW+1)-1:0]  sums_o
);

  localparam int NO = N_IN / 2;
  localparam int OW = IW + 1;

  logic [NO*OW-1:0] sum_d;

  always_comb begin
    sum_d = '0;
    for (int i = 0; i < NO; i++)
      sum_d[i*OW +: OW] = OW'(sums_i[2*i*IW +: IW]) + OW'(sums_i[(2*i+1)*IW +: IW]);
  end

  if (REG) begin : g_reg
    logic [NO*OW-1:0] sum_q;
    always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n)  sum_q <= '0;
      else if (en_i) sum_q <= sum_d;
    end
    assign sums_o = sum_q;
  end else begin : g_comb
    logic unused_ctl;
    assign unused_ctl = ^{clock, reset_n, en_i};
    assign sums_o     = sum_d;
  end

endmodule

// File: rtl/popcount_pipe.sv
// Pipelined population count with below-threshold flag and saturating hit total.
// Define POPCOUNT_PIPE_MASK_EN to add in_mask (counted vector = in_data & in_mask).
module popcount_pipe
  import popcount_pkg::*;
#(
  parameter int          WIDTH     = 8,
  parameter int          REG_EVERY = 1,
  parameter int unsigned THRESHOLD = DEF_THRESHOLD,
  parameter int          ACC_W     = DEF_ACC_W
) (
  input  logic                        clock,
  input  logic                        reset_n,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [WIDTH-1:0]            in_data,
`ifdef POPCOUNT_PIPE_MASK_EN
  input  logic [WIDTH-1:0]            in_mask,
`endif
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [count_w(WIDTH)-1:0]   out_count,
  output logic                        out_hit,
  input  logic                        clear_acc,
  output logic [ACC_W-1:0]            hit_total
);

  localparam int CW  = count_w(WIDTH);
  localparam int D   = clog2_f(WIDTH);
  localparam int N   = 1 << D;
  localparam int SW  = D + 1;
  localparam int LAT = pipe_lat(WIDTH, REG_EVERY);

  logic             advance;
  logic [WIDTH-1:0] vec;
  logic [N-1:0]     leaves;
  logic [SW-1:0]    sum;
  logic [LAT-1:0]   vld_q;
  logic [LAT:0]     vld_pipe;
  logic [CW-1:0]    cnt_d, cnt_q;
  logic             hit_d, hit_q;
  logic [ACC_W-1:0] hit_total_d, hit_total_q;

  assign advance = !out_valid || out_ready;
  assign in_ready = advance;

  // Idle beats feed zeros so stale or unknown data never reaches the tree.
`ifdef POPCOUNT_PIPE_MASK_EN
  assign vec = in_valid ? (in_data & in_mask) : '0;
`else
  assign vec = in_valid ? in_data : '0;
`endif
  assign leaves = N'(vec);

  if (D == 0) begin : g_one
    assign sum = leaves;
  end else begin : g_tree
    localparam int TOT = tree_off(N, D);
    logic [TOT-1:0] tree;
    for (genvar k = 0; k < D; k++) begin : g_lvl
      localparam int NI = N >> k;
      logic [NI*(k+1)-1:0] lvl_in;
      if (k == 0) begin : g_in0
        assign lvl_in = leaves;
      end else begin : g_inn
        assign lvl_in = tree[tree_off(N, k-1) +: NI*(k+1)];
      end
      // The last level stays combinational: the output register closes it.
      popcount_tree_level #(
        .N_IN (NI),
        .IW   (k + 1),
        .REG  (((k + 1) % REG_EVERY == 0) && (k != D - 1))
      ) u_lvl (
        .clock   (clock),
        .reset_n (reset_n),
        .en_i    (advance),
        .sums_i  (lvl_in),
        .sums_o  (tree[tree_off(N, k) +: (NI/2)*(k+2)])
      );
    end
    assign sum = tree[TOT-1 -: SW];
  end

  assign cnt_d = CW'(sum);
  assign hit_d = (32'(sum) < THRESHOLD);

  assign vld_pipe  = {vld_q, in_valid};
  assign out_valid = vld_pipe[LAT];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      vld_q <= '0;
      cnt_q <= '0;
      hit_q <= 1'b0;
    end else if (advance) begin
      vld_q <= vld_pipe[LAT-1:0];
      cnt_q <= cnt_d;
      hit_q <= hit_d;
    end
  end

  assign out_count = cnt_q;
  assign out_hit   = hit_q;

  // Clear wins over a same-cycle hit; the total sticks at all-ones.
  always_comb begin
    hit_total_d = hit_total_q;
    if (clear_acc)
      hit_total_d = '0;
    else if (out_valid && out_ready && out_hit && (hit_total_q != '1))
      hit_total_d = hit_total_q + ACC_W'(1);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) hit_total_q <= '0;
    else          hit_total_q <= hit_total_d;
  end

  assign hit_total = hit_total_q;

endmodule

// File: tb/tb_popcount_pipe.sv
// Directed bench for popcount_pipe: streaming, backpressure, odd widths,
// accumulator saturation/clear, mid-flight reset and (optionally) masking.
module tb_popcount_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, iv, ordy, clr;
  logic [7:0] d8, m8;
  logic [8:0] d9, m9;
  logic [0:0] d1, m1;

  logic ov8, rdy8, hit8; logic [3:0] cnt8; logic [31:0] ht8;
  logic ov3, rdy3, hit3; logic [3:0] cnt3; logic [31:0] ht3;
  logic ov9, rdy9, hit9; logic [3:0] cnt9; logic [31:0] ht9;
  logic ov1, rdy1, hit1; logic [0:0] cnt1; logic [31:0] ht1;
  logic ova, rdya, hita; logic [3:0] cnta; logic [1:0]  hta;

  popcount_pipe #(.WIDTH(8)) u8 (
    .clock(clk), .reset_n(rst_n), .in_valid(iv), .in_ready(rdy8), .in_data(d8),
`ifdef POPCOUNT_PIPE_MASK_EN
    .in_mask(m8),
`endif
    .out_valid(ov8), .out_ready(ordy), .out_count(cnt8), .out_hit(hit8),
    .clear_acc(clr), .hit_total(ht8));

  popcount_pipe #(.WIDTH(8), .REG_EVERY(3)) u3 (
    .clock(clk), .reset_n(rst_n), .in_valid(iv), .in_ready(rdy3), .in_data(d8),
`ifdef POPCOUNT_PIPE_MASK_EN
    .in_mask(m8),
`endif
    .out_valid(ov3), .out_ready(ordy), .out_count(cnt3), .out_hit(hit3),
    .clear_acc(clr), .hit_total(ht3));

  popcount_pipe #(.WIDTH(9), .REG_EVERY(2)) u9 (
    .clock(clk), .reset_n(rst_n), .in_valid(iv), .in_ready(rdy9), .in_data(d9),
`ifdef POPCOUNT_PIPE_MASK_EN
    .in_mask(m9),
`endif
    .out_valid(ov9), .out_ready(ordy), .out_count(cnt9), .out_hit(hit9),
    .clear_acc(clr), .hit_total(ht9));

  popcount_pipe #(.WIDTH(1)) u1 (
    .clock(clk), .reset_n(rst_n), .in_valid(iv), .in_ready(rdy1), .in_data(d1),
`ifdef POPCOUNT_PIPE_MASK_EN
    .in_mask(m1),
`endif
    .out_valid(ov1), .out_ready(ordy), .out_count(cnt1), .out_hit(hit1),
    .clear_acc(clr), .hit_total(ht1));

  popcount_pipe #(.WIDTH(8), .ACC_W(2)) ua (
    .clock(clk), .reset_n(rst_n), .in_valid(iv), .in_ready(rdya), .in_data(d8),
`ifdef POPCOUNT_PIPE_MASK_EN
    .in_mask(m8),
`endif
    .out_valid(ova), .out_ready(ordy), .out_count(cnta), .out_hit(hita),
    .clear_acc(clr), .hit_total(hta));

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0; iv = 1'b0; clr = 1'b0; ordy = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  typedef struct { logic [7:0] d; int c; int h; } vec_t;
  vec_t t1[7];
  logic [7:0] t2d[3];
  int t2c[3];
  int t4[5];

  initial begin
    t1[0] = '{8'h00, 0, 1}; t1[1] = '{8'hFF, 8, 0}; t1[2] = '{8'hA5, 4, 0};
    t1[3] = '{8'h07, 3, 1}; t1[4] = '{8'h80, 1, 1}; t1[5] = '{8'h3C, 4, 0};
    t1[6] = '{8'hFE, 7, 0};
    t2d[0] = 8'h0F; t2d[1] = 8'h01; t2d[2] = 8'h03;
    t2c[0] = 4;     t2c[1] = 1;     t2c[2] = 2;
    t4[0] = 1; t4[1] = 2; t4[2] = 3; t4[3] = 3; t4[4] = 3;

    rst_n = 1'b0; iv = 1'b0; ordy = 1'b1; clr = 1'b0;
    d8 = '0; d9 = '0; d1 = '0; m8 = '1; m9 = '1; m1 = '1;
    repeat (2) @(posedge clk);
    #1;
    // Reset state of every instance
    chk("rst_ov8", int'(ov8), 0);  chk("rst_cnt8", int'(cnt8), 0);
    chk("rst_hit8", int'(hit8), 0); chk("rst_ht8", int'(ht8), 0);
    chk("rst_rdy8", int'(rdy8), 1);
    chk("rst_ov3", int'(ov3), 0);  chk("rst_hit3", int'(hit3), 0);
    chk("rst_ht3", int'(ht3), 0);  chk("rst_rdy3", int'(rdy3), 1);
    chk("rst_ov9", int'(ov9), 0);  chk("rst_hit9", int'(hit9), 0);
    chk("rst_ht9", int'(ht9), 0);  chk("rst_rdy9", int'(rdy9), 1);
    chk("rst_ov1", int'(ov1), 0);  chk("rst_hit1", int'(hit1), 0);
    chk("rst_ht1", int'(ht1), 0);  chk("rst_rdy1", int'(rdy1), 1);
    chk("rst_ova", int'(ova), 0);  chk("rst_cnta", int'(cnta), 0);
    chk("rst_hita", int'(hita), 0); chk("rst_hta", int'(hta), 0);
    chk("rst_rdya", int'(rdya), 1);
    rst_n = 1'b1;

    // Back-to-back stream: LAT=3 on u8, LAT=1 on u3
    for (int c = 0; c < 10; c++) begin
      iv = (c < 7);
      d8 = (c < 7) ? t1[c].d : 8'h00;
      @(posedge clk); #1;
      if (c >= 2 && c - 2 < 7) begin
        chk("t1_ov8", int'(ov8), 1);
        chk("t1_cnt8", int'(cnt8), t1[c-2].c);
        chk("t1_hit8", int'(hit8), t1[c-2].h);
      end else chk("t1_ov8_idle", int'(ov8), 0);
      if (c < 7) begin
        chk("t1_ov3", int'(ov3), 1);
        chk("t1_cnt3", int'(cnt3), t1[c].c);
      end else chk("t1_ov3_idle", int'(ov3), 0);
    end
    iv = 1'b0;
    @(posedge clk); #1;
    chk("t1_hit_total", int'(ht8), 3);

    // Backpressure: out_ready low 4 cycles from first out_valid
    do_reset();
    begin
      int sent, got, stall, cur;
      bit first, acc_in, acc_out;
      sent = 0; got = 0; stall = 0; first = 0;
      for (int c = 0; c < 40 && got < 3; c++) begin
        if (ov8 && !first) begin first = 1; stall = 4; end
        ordy = (stall == 0);
        iv   = (sent < 3);
        d8   = (sent < 3) ? t2d[sent] : 8'h00;
        #1;
        if (stall > 0) begin
          chk("t2_stall_rdy", int'(rdy8), 0);
          chk("t2_hold_cnt", int'(cnt8), 4);
          chk("t2_hold_ov", int'(ov8), 1);
        end
        acc_in  = iv && rdy8;
        acc_out = ov8 && ordy;
        cur     = int'(cnt8);
        @(posedge clk); #1;
        if (acc_in) sent++;
        if (acc_out) begin
          if (got < 3) chk("t2_order", cur, t2c[got]);
          got++;
        end
        if (stall > 0) stall--;
      end
      chk("t2_got", got, 3);
      iv = 1'b0; ordy = 1'b1;
      for (int c = 0; c < 3; c++) begin
        @(posedge clk); #1;
        chk("t2_no_dup", int'(ov8), 0);
      end
    end

    // Odd widths: W=9/R=2 (LAT=2), W=1 (LAT=1), W=8/R=3 (LAT=1)
    do_reset();
    iv = 1'b1; d9 = 9'h1FF; d1 = 1'b1; d8 = 8'hA5;
    @(posedge clk); #1;
    iv = 1'b0;
    chk("t3_ov1", int'(ov1), 1);  chk("t3_cnt1", int'(cnt1), 1);
    chk("t3_hit1", int'(hit1), 1); chk("t3_ov9_early", int'(ov9), 0);
    chk("t3_ov3", int'(ov3), 1);  chk("t3_cnt3", int'(cnt3), 4);
    @(posedge clk); #1;
    chk("t3_ov9", int'(ov9), 1);  chk("t3_cnt9", int'(cnt9), 9);
    chk("t3_hit9", int'(hit9), 0); chk("t3_ov1_done", int'(ov1), 0);

    // Saturating 2-bit accumulator, then clear during a hit
    do_reset();
    d8 = 8'h00;
    for (int c = 0; c < 8; c++) begin
      iv = (c < 5);
      @(posedge clk); #1;
      if (c >= 3) chk("t4_sat", int'(hta), t4[c-3]);
    end
    for (int c = 0; c < 5; c++) begin
      iv  = (c == 0);
      clr = (c == 3);
      @(posedge clk); #1;
      if (c == 2) chk("t4_hit_pending", int'(ova && hita), 1);
      if (c >= 3) chk("t4_clear", int'(hta), 0);
    end
    clr = 1'b0;

    // Reset with beats in flight
    do_reset();
    d8 = 8'h00;
    for (int c = 0; c < 4; c++) begin
      iv = 1'b1;
      @(posedge clk); #1;
    end
    iv = 1'b0;
    chk("t5_pre_ov", int'(ov8), 1);
    chk("t5_pre_ht", int'(ht8), 1);
    rst_n = 1'b0;
    #1;
    chk("t5_async_ov", int'(ov8), 0);
    chk("t5_async_ht", int'(ht8), 0);
    chk("t5_async_cnt", int'(cnt8), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      chk("t5_no_stale", int'(ov8), 0);
    end
    chk("t5_ht", int'(ht8), 0);

`ifdef POPCOUNT_PIPE_MASK_EN
    do_reset();
    iv = 1'b1; d8 = 8'hFF; m8 = 8'hEF;
    @(posedge clk); #1;
    iv = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("t6_ov", int'(ov8), 1);
    chk("t6_cnt", int'(cnt8), 7);
    chk("t6_hit", int'(hit8), 0);
    m8 = '1;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

endmodule

// File: doc/popcount_pipe.md
Name: popcount_pipe

Overview:
- Parametrised, pipelined successor to the 8-bit combinational ones-counter used by the grid-neighbour logic.
- Accepts a WIDTH-bit neighbour vector per beat over valid/ready.
- Emits its population count plus a below-threshold flag.
- Keeps a running count of below-threshold beats, giving the puzzle's "accessible cell" total directly.

Parameters:
- WIDTH, 8: input vector width in bits; legal range is 1 to 256.
- REG_EVERY, 1: adder-tree levels between pipeline registers; legal range is 1 or more.
- THRESHOLD, 4: a beat is a "hit" when its count is strictly less than THRESHOLD.
- ACC_W, 32: hit accumulator width.

Ports:
- clock  in  1  rising-edge clock.
- reset_n  in  1  asynchronous active-low reset.
- in_valid  in  1  input beat valid.
- in_ready  out  1  input beat accepted when in_valid && in_ready.
- in_data  in  WIDTH  vector to count.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts result.
- out_count  out  CW  number of ones, where CW = $clog2(WIDTH+1).
- out_hit  out  1  out_count < THRESHOLD.
- clear_acc  in  1  synchronous clear of hit_total.
- hit_total  out  ACC_W  saturating count of accepted hit results.

Behaviour:
- Reset: one clock, asynchronous active-low reset. While reset_n is low, all stage-valid flags, out_valid, out_count, out_hit and hit_total are 0.
- Tree structure: balanced binary adder tree of depth D = $clog2(WIDTH).
  - Pad leaves with zeros to 2^D.
  - Level-k partial sums are k+1 bits wide and zero-extended, never truncated.
  - The final sum is truncated to CW bits, which is lossless.
- Latency:
  - Pipeline stages LAT = max(1, ceil(D/REG_EVERY)).
  - Registers sit after every REG_EVERY levels; the last register is always the output register.
  - WIDTH=8, REG_EVERY=1 gives LAT=3. WIDTH=8, REG_EVERY=3 gives LAT=1. WIDTH=1 gives LAT=1.
- Flow control:
  - Global stall, with advance = !out_valid || out_ready, and in_ready = advance (combinational).
  - When advance=1, every stage shifts data and its valid flag forward; stage 0 captures in_valid.
  - When advance=0, every stage holds.
  - Bubbles are not compressed.
  - out_valid, out_count and out_hit stay stable while out_valid && !out_ready.
- Throughput: one beat per cycle when out_ready is held at 1.
- out_hit is registered alongside out_count in the output stage. THRESHOLD=0 gives out_hit always 0. THRESHOLD > WIDTH gives out_hit always 1.
- hit_total update:
  - It increments by 1 on each cycle where out_valid && out_ready && out_hit.
  - It saturates at 2^ACC_W-1; there is no wrap.
  - clear_acc=1 forces 0 on the next edge and takes priority over a simultaneous increment. That increment is lost.
- Reset mid-operation: in-flight beats are discarded; there is no partial output.
- in_data is ignored when in_valid=0, and X on in_data must not propagate to the outputs.

Optional Feature:
- Macro: POPCOUNT_PIPE_MASK_EN.
- Defined: adds port in_mask (in, WIDTH). The counted vector is in_data & in_mask, sampled with the beat. This is used to exclude the centre cell or off-grid neighbours at edges.
- Undefined: the port is absent and all WIDTH bits are counted.
- Latency and handshake are identical in both builds.

Decomposition:
- Package popcount_pkg holds:
  - function clog2_f;
  - function count_w(width), returning $clog2(width+1);
  - function pipe_lat(width, reg_every);
  - localparam defaults for THRESHOLD and ACC_W.
- One sub-module, popcount_tree_level: one adder level with a generic-width input vector of sums, producing a halved vector of sums one bit wider, plus an optional register (parameter REG).
- The top level chains the level instances, and owns the valid pipeline, threshold compare and accumulator.

Test Plan:
1. WIDTH=8, REG_EVERY=1, out_ready=1; stream 8'h00, 8'hFF, 8'hA5, 8'h07 back-to-back.
   - Counts 0, 8, 4, 3 appear on cycles 3 to 6 after the first accept.
   - out_hit = 1, 0, 0, 1.
   - hit_total = 2.
2. Backpressure: stream 8'h0F, 8'h01, 8'h03 with out_ready low for 4 cycles after the first out_valid.
   - out_count holds at 4 and in_ready=0 while stalled.
   - Release gives 4, 1, 2 in order, with none lost or duplicated.
3. WIDTH=9, REG_EVERY=2, input 9'h1FF: LAT=2 and out_count=9 (CW=4). WIDTH=1, input 1: LAT=1 and count=1.
4. ACC_W=2; send 5 hit beats (8'h00).
   - hit_total goes 1, 2, 3, 3, 3.
   - clear_acc asserted during a hit acceptance gives hit_total=0 on the next cycle.
5. Assert reset_n low with 2 beats in flight: out_valid=0 immediately, no stale output after release, hit_total=0.
6. POPCOUNT_PIPE_MASK_EN defined; in_data=8'hFF, in_mask=8'hEF: out_count=7, out_hit=0.
